writeback_buffered: RTL and testbench

Parametrised write-back stage with a DEPTH-entry retire buffer between the memory stage and the register-file write port. It selects the result source per instruction (ALU, load, CSR), extends load data, and queues completed results behind a valid/ready handshake. It drains the queue into a register-file port that can refuse writes. It also produces per-retire next-PC and an instruction-retired counter.

---
 rtl/writeback_buffered_pkg.sv | 37 +++
 rtl/writeback_buffered_if.sv | 49 ++++
 rtl/header.vh | 15 +
 rtl/writeback_buffered_wb_fifo.sv | 52 +++++
 rtl/writeback_buffered.sv | 126 ++++++++++++
 tb/tb_writeback_buffered.sv | 264 ++++++++++++++++++++++++++
 6 files changed

// File: rtl/writeback_buffered_pkg.sv
// Package for writeback_buffered: opcode/funct constants and result-source selection.
`include "header.vh"

package writeback_buffered_pkg;

  localparam int OPCODE_W = `OPCODE_WIDTH;

  localparam logic [OPCODE_W-1:0] OP_LOAD   = `OPCODE_LOAD;
  localparam logic [OPCODE_W-1:0] OP_SYSTEM = `OPCODE_SYSTEM;

  localparam logic [2:0] F3_LB  = `FUNCT3_LB;
  localparam logic [2:0] F3_LH  = `FUNCT3_LH;
  localparam logic [2:0] F3_LW  = `FUNCT3_LW;
  localparam logic [2:0] F3_LBU = `FUNCT3_LBU;
  localparam logic [2:0] F3_LHU = `FUNCT3_LHU;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_LOAD = 2'd1,
    SRC_CSR  = 2'd2
  } wb_src_e;

  // CSR reads are SYSTEM instructions with a non-zero funct3; ECALL/EBREAK fall to ALU
  function automatic wb_src_e select_src(input logic [OPCODE_W-1:0] opcode,
                                         input logic funct_nonzero);
    wb_src_e src;
    if (opcode == OP_LOAD) begin
      src = SRC_LOAD;
    end else if ((opcode == OP_SYSTEM) && funct_nonzero) begin
      src = SRC_CSR;
    end else begin
      src = SRC_ALU;
    end
    return src;
  endfunction

endpackage

// File: rtl/writeback_buffered_if.sv
// Memory-stage / register-file bus of writeback_buffered; master drives the wb_i_* side.
interface writeback_buffered_if
  import writeback_buffered_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 32
);
  logic                    wb_i_valid;
  logic                    wb_o_ready;
  logic [OPCODE_W-1:0]     wb_i_opcode;
  logic [FUNCT_WIDTH-1:0]  wb_i_funct;
  logic [1:0]              wb_i_addr_lo;
  logic                    wb_i_we_rd;
  logic [AWIDTH-1:0]       wb_i_rd_addr;
  logic [DWIDTH-1:0]       wb_i_rd_data;
  logic [DWIDTH-1:0]       wb_i_data_load;
  logic [DWIDTH-1:0]       wb_i_csr;
  logic [PC_WIDTH-1:0]     wb_i_pc;
  logic                    wb_i_flush;
  logic                    wb_i_stall;
  logic                    wb_i_rf_ready;
  logic                    wb_o_valid;
  logic                    wb_o_we_rd;
  logic [AWIDTH-1:0]       wb_o_rd_addr;
  logic [DWIDTH-1:0]       wb_o_rd_data;
  logic [PC_WIDTH-1:0]     wb_o_next_pc;
  logic [$clog2(DEPTH):0]  wb_o_count;
  logic [CNT_WIDTH-1:0]    wb_o_retire_cnt;

  modport master (
    output wb_i_valid, wb_i_opcode, wb_i_funct, wb_i_addr_lo, wb_i_we_rd, wb_i_rd_addr,
           wb_i_rd_data, wb_i_data_load, wb_i_csr, wb_i_pc, wb_i_flush, wb_i_stall,
           wb_i_rf_ready,
    input  wb_o_ready, wb_o_valid, wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data, wb_o_next_pc,
           wb_o_count, wb_o_retire_cnt
  );

  modport slave (
    input  wb_i_valid, wb_i_opcode, wb_i_funct, wb_i_addr_lo, wb_i_we_rd, wb_i_rd_addr,
           wb_i_rd_data, wb_i_data_load, wb_i_csr, wb_i_pc, wb_i_flush, wb_i_stall,
           wb_i_rf_ready,
    output wb_o_ready, wb_o_valid, wb_o_we_rd, wb_o_rd_addr, wb_o_rd_data, wb_o_next_pc,
           wb_o_count, wb_o_retire_cnt
  );
endinterface

// File: rtl/header.vh
// Shared opcode and load-type constants for the write-back stage.
`ifndef WB_HEADER_VH
`define WB_HEADER_VH

`define OPCODE_WIDTH  7
`define OPCODE_LOAD   7'b0000011
`define OPCODE_SYSTEM 7'b1110011

`define FUNCT3_LB  3'd0
`define FUNCT3_LH  3'd1
`define FUNCT3_LW  3'd2
`define FUNCT3_LBU 3'd4
`define FUNCT3_LHU 3'd5

`endif

// File: rtl/writeback_buffered_wb_fifo.sv
// Retire buffer: DEPTH-entry circular FIFO with flush and simultaneous push/pop.
module writeback_buffered_wb_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W:0]   count_r;

  // Storage write on an accepted push
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {(PTR_W+1){1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
endmodule

// File: rtl/writeback_buffered.sv
// Buffered write-back stage: result select, load extension, retire FIFO, retire counter.
// Optional load shift/extension is enabled by defining WB_LOAD_EXT_EN.
module writeback_buffered
  import writeback_buffered_pkg::*;
#(
  parameter int DWIDTH      = 32,
  parameter int AWIDTH      = 5,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3,
  parameter int DEPTH       = 4,
  parameter int CNT_WIDTH   = 32
) (
  input logic                 wb_clk,
  input logic                 wb_rst,
  writeback_buffered_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef struct packed {
    logic                we;
    logic [AWIDTH-1:0]   rd_addr;
    logic [DWIDTH-1:0]   data;
    logic [PC_WIDTH-1:0] next_pc;
  } entry_t;

  logic                 valid_s;
  logic                 pop_s;
  logic                 push_s;
  logic                 ready_s;
  logic [DWIDTH-1:0]    load_ext_s;
  logic [DWIDTH-1:0]    result_s;
  entry_t               entry_s;
  entry_t               head_s;
  logic [CNT_W-1:0]     count_s;
  logic [CNT_WIDTH-1:0] retire_cnt_r;

  assign valid_s = (count_s != {CNT_W{1'b0}});
  assign pop_s   = valid_s && bus.wb_i_rf_ready && !bus.wb_i_stall && !bus.wb_i_flush;
  assign ready_s = !wb_rst && ((count_s < FULL_CNT) || pop_s);
  assign push_s  = bus.wb_i_valid && ready_s && !bus.wb_i_flush;

`ifdef WB_LOAD_EXT_EN
  logic [DWIDTH-1:0] shifted_s;

  // Align the addressed byte to bit 0, then sign/zero extend per load type
  always_comb begin
    shifted_s = bus.wb_i_data_load >> {bus.wb_i_addr_lo, 3'b000};
    case (bus.wb_i_funct)
      FUNCT_WIDTH'(F3_LB):  load_ext_s = {{(DWIDTH-8){shifted_s[7]}}, shifted_s[7:0]};
      FUNCT_WIDTH'(F3_LH):  load_ext_s = {{(DWIDTH-16){shifted_s[15]}}, shifted_s[15:0]};
      FUNCT_WIDTH'(F3_LW):  load_ext_s = shifted_s;
      FUNCT_WIDTH'(F3_LBU): load_ext_s = {{(DWIDTH-8){1'b0}}, shifted_s[7:0]};
      FUNCT_WIDTH'(F3_LHU): load_ext_s = {{(DWIDTH-16){1'b0}}, shifted_s[15:0]};
      default:              load_ext_s = shifted_s;
    endcase
  end
`else
  logic unused_addr_lo_s;
  assign unused_addr_lo_s = ^bus.wb_i_addr_lo;

  // Raw load word passes through unmodified
  always_comb begin
    load_ext_s = bus.wb_i_data_load;
  end
`endif

  // Result source select and entry assembly; writes to x0 never enable the port
  always_comb begin
    case (select_src(bus.wb_i_opcode, |bus.wb_i_funct))
      SRC_LOAD: result_s = load_ext_s;
      SRC_CSR:  result_s = bus.wb_i_csr;
      SRC_ALU:  result_s = bus.wb_i_rd_data;
      default:  result_s = bus.wb_i_rd_data;
    endcase
    entry_s.we      = bus.wb_i_we_rd && (bus.wb_i_rd_addr != {AWIDTH{1'b0}});
    entry_s.rd_addr = bus.wb_i_rd_addr;
    entry_s.data    = result_s;
    entry_s.next_pc = bus.wb_i_pc + PC_WIDTH'(4);
  end

  writeback_buffered_wb_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push_s),
    .pop   (pop_s),
    .flush (bus.wb_i_flush),
    .din   (entry_s),
    .dout  (head_s),
    .count (count_s)
  );

  // Retired-instruction counter; survives flush, cleared only by reset
  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      retire_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (pop_s) begin
      retire_cnt_r <= retire_cnt_r + CNT_WIDTH'(1);
    end else begin
      retire_cnt_r <= retire_cnt_r;
    end
  end

  // Head outputs are zero whenever the buffer is empty
  always_comb begin
    if (valid_s) begin
      bus.wb_o_we_rd   = head_s.we;
      bus.wb_o_rd_addr = head_s.rd_addr;
      bus.wb_o_rd_data = head_s.data;
      bus.wb_o_next_pc = head_s.next_pc;
    end else begin
      bus.wb_o_we_rd   = 1'b0;
      bus.wb_o_rd_addr = {AWIDTH{1'b0}};
      bus.wb_o_rd_data = {DWIDTH{1'b0}};
      bus.wb_o_next_pc = {PC_WIDTH{1'b0}};
    end
  end

  assign bus.wb_o_valid      = valid_s;
  assign bus.wb_o_ready      = ready_s;
  assign bus.wb_o_count      = count_s;
  assign bus.wb_o_retire_cnt = retire_cnt_r;
endmodule

// File: tb/tb_writeback_buffered.sv
// Directed bench for writeback_buffered with a queue scoreboard of expected retires.
module tb_writeback_buffered;
  import writeback_buffered_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int PW = 32;
  localparam int FW = 3;
  localparam int DEPTH = 4;
  localparam int CW = 32;
  localparam logic [OPCODE_W-1:0] OP_ALU = OPCODE_W'(7'h33);

  typedef struct packed {
    logic          we;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic [PW-1:0] npc;
  } exp_t;

  logic wb_clk = 1'b0;
  logic wb_rst;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t sb_q[$];
  logic [CW-1:0] m_retire = 32'd0;

  logic [2:0]    ld_funct [3] = '{3'd0, 3'd4, 3'd1};
  logic [1:0]    ld_addr  [3] = '{2'd3, 2'd3, 2'd2};
`ifdef WB_LOAD_EXT_EN
  logic [DW-1:0] ld_exp   [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};
`else
  logic [DW-1:0] ld_exp   [3] = '{32'h80FF7F01, 32'h80FF7F01, 32'h80FF7F01};
`endif

  always #5 wb_clk = ~wb_clk;

  writeback_buffered_if #(
    .DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW), .FUNCT_WIDTH(FW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) bus_if ();

  writeback_buffered #(
    .DWIDTH(DW), .AWIDTH(AW), .PC_WIDTH(PW), .FUNCT_WIDTH(FW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus_if)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_load(input logic [DW-1:0] w, input logic [1:0] a,
                                               input logic [2:0] f);
`ifdef WB_LOAD_EXT_EN
    logic [DW-1:0] s;
    s = w >> (8 * a);
    case (f)
      3'd0:    return {{24{s[7]}}, s[7:0]};
      3'd1:    return {{16{s[15]}}, s[15:0]};
      3'd4:    return {24'h000000, s[7:0]};
      3'd5:    return {16'h0000, s[15:0]};
      default: return s;
    endcase
`else
    logic unused_args;
    unused_args = ^{a, f};
    return w;
`endif
  endfunction

  function automatic exp_t model_entry();
    exp_t e;
    if (bus_if.wb_i_opcode == OP_LOAD)
      e.data = model_load(bus_if.wb_i_data_load, bus_if.wb_i_addr_lo, bus_if.wb_i_funct);
    else if (bus_if.wb_i_opcode == OP_SYSTEM && bus_if.wb_i_funct != 3'd0)
      e.data = bus_if.wb_i_csr;
    else
      e.data = bus_if.wb_i_rd_data;
    e.we  = bus_if.wb_i_we_rd && (bus_if.wb_i_rd_addr != 5'd0);
    e.rd  = bus_if.wb_i_rd_addr;
    e.npc = bus_if.wb_i_pc + 32'd4;
    return e;
  endfunction

  // Check every output against the model, then advance one clock and update the model.
  task automatic tick();
    logic pop_e, ready_e, push_e, rst_e, flush_e;
    exp_t nxt;
    #1;
    pop_e   = (sb_q.size() != 0) && bus_if.wb_i_rf_ready && !bus_if.wb_i_stall && !bus_if.wb_i_flush;
    ready_e = !wb_rst && ((sb_q.size() < DEPTH) || pop_e);
    push_e  = bus_if.wb_i_valid && ready_e && !bus_if.wb_i_flush;
    rst_e   = wb_rst;
    flush_e = bus_if.wb_i_flush;
    nxt     = model_entry();
    chk("ready", bus_if.wb_o_ready, ready_e);
    chk("count", bus_if.wb_o_count, sb_q.size());
    chk("valid", bus_if.wb_o_valid, sb_q.size() != 0);
    chk("retire_cnt", bus_if.wb_o_retire_cnt, m_retire);
    if (sb_q.size() != 0) begin
      chk("head_we", bus_if.wb_o_we_rd, sb_q[0].we);
      chk("head_rd", bus_if.wb_o_rd_addr, sb_q[0].rd);
      chk("head_data", bus_if.wb_o_rd_data, sb_q[0].data);
      chk("head_npc", bus_if.wb_o_next_pc, sb_q[0].npc);
    end else begin
      chk("empty_we", bus_if.wb_o_we_rd, 1'b0);
      chk("empty_rd", bus_if.wb_o_rd_addr, 5'd0);
      chk("empty_data", bus_if.wb_o_rd_data, 32'd0);
      chk("empty_npc", bus_if.wb_o_next_pc, 32'd0);
    end
    @(posedge wb_clk);
    if (rst_e) begin
      sb_q.delete();
      m_retire = 32'd0;
    end else if (flush_e) begin
      sb_q.delete();
    end else begin
      if (pop_e) begin
        void'(sb_q.pop_front());
        m_retire = m_retire + 32'd1;
      end
      if (push_e) sb_q.push_back(nxt);
    end
    #1;
  endtask

  task automatic drive(input logic [OPCODE_W-1:0] op, input logic [2:0] f, input logic [1:0] alo,
                       input logic we, input logic [4:0] rd, input logic [31:0] d,
                       input logic [31:0] ld, input logic [31:0] csr, input logic [31:0] pc);
    bus_if.wb_i_opcode    = op;
    bus_if.wb_i_funct     = f;
    bus_if.wb_i_addr_lo   = alo;
    bus_if.wb_i_we_rd     = we;
    bus_if.wb_i_rd_addr   = rd;
    bus_if.wb_i_rd_data   = d;
    bus_if.wb_i_data_load = ld;
    bus_if.wb_i_csr       = csr;
    bus_if.wb_i_pc        = pc;
  endtask

  task automatic push_one(input logic [4:0] rd, input logic [31:0] d, input logic [31:0] pc);
    drive(OP_ALU, 3'd0, 2'd0, 1'b1, rd, d, 32'd0, 32'd0, pc);
    bus_if.wb_i_valid = 1'b1;
    tick();
    bus_if.wb_i_valid = 1'b0;
  endtask

  initial begin
    wb_rst = 1'b1;
    bus_if.wb_i_valid = 1'b0;
    bus_if.wb_i_flush = 1'b0;
    bus_if.wb_i_stall = 1'b0;
    bus_if.wb_i_rf_ready = 1'b0;
    drive(OP_ALU, 3'd0, 2'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(posedge wb_clk);
    #1;
    tick();
    tick();
    wb_rst = 1'b0;

    // Basic push and retire
    bus_if.wb_i_rf_ready = 1'b1;
    push_one(5'd5, 32'h1234, 32'h100);
    chk("basic_valid", bus_if.wb_o_valid, 1'b1);
    chk("basic_we", bus_if.wb_o_we_rd, 1'b1);
    chk("basic_rd", bus_if.wb_o_rd_addr, 5'd5);
    chk("basic_data", bus_if.wb_o_rd_data, 32'h1234);
    chk("basic_npc", bus_if.wb_o_next_pc, 32'h104);
    tick();
    chk("basic_retire", bus_if.wb_o_retire_cnt, 32'd1);

    // Load extension table
    for (int i = 0; i < 3; i++) begin
      drive(OP_LOAD, ld_funct[i], ld_addr[i], 1'b1, 5'd7, 32'hAAAA, 32'h80FF7F01, 32'd0, 32'h200);
      bus_if.wb_i_valid = 1'b1;
      tick();
      bus_if.wb_i_valid = 1'b0;
      chk("load_data", bus_if.wb_o_rd_data, ld_exp[i]);
      tick();
    end

    // CSR read and x0 destination
    drive(OP_SYSTEM, 3'd2, 2'd0, 1'b1, 5'd9, 32'h5555, 32'd0, 32'hDEAD, 32'h300);
    bus_if.wb_i_valid = 1'b1;
    tick();
    bus_if.wb_i_valid = 1'b0;
    chk("csr_data", bus_if.wb_o_rd_data, 32'hDEAD);
    tick();
    push_one(5'd0, 32'h77, 32'h304);
    chk("x0_we", bus_if.wb_o_we_rd, 1'b0);
    tick();
    chk("x0_retire", bus_if.wb_o_retire_cnt, 32'd6);

    // Backpressure: fill, then push+pop while full, then drain in order
    bus_if.wb_i_rf_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(5'(10 + i), 32'h100 + 32'(i), 32'h400 + 32'(4 * i));
    #1;
    chk("bp_count_full", bus_if.wb_o_count, 3'd4);
    chk("bp_ready_full", bus_if.wb_o_ready, 1'b0);
    drive(OP_ALU, 3'd0, 2'd0, 1'b1, 5'd14, 32'h104, 32'd0, 32'd0, 32'h410);
    bus_if.wb_i_valid = 1'b1;
    bus_if.wb_i_rf_ready = 1'b1;
    #1;
    chk("bp_ready_pop", bus_if.wb_o_ready, 1'b1);
    tick();
    bus_if.wb_i_valid = 1'b0;
    chk("bp_count_same", bus_if.wb_o_count, 3'd4);
    chk("bp_head_second", bus_if.wb_o_rd_addr, 5'd11);
    repeat (4) tick();
    chk("bp_drained", bus_if.wb_o_count, 3'd0);
    chk("bp_retire", bus_if.wb_o_retire_cnt, 32'd11);

    // Flush with an incoming entry
    bus_if.wb_i_rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one(5'(20 + i), 32'h200 + 32'(i), 32'h500);
    drive(OP_ALU, 3'd0, 2'd0, 1'b1, 5'd23, 32'h2FF, 32'd0, 32'd0, 32'h50C);
    bus_if.wb_i_valid = 1'b1;
    bus_if.wb_i_flush = 1'b1;
    bus_if.wb_i_rf_ready = 1'b1;
    tick();
    bus_if.wb_i_valid = 1'b0;
    bus_if.wb_i_flush = 1'b0;
    chk("flush_count", bus_if.wb_o_count, 3'd0);
    chk("flush_valid", bus_if.wb_o_valid, 1'b0);
    chk("flush_retire", bus_if.wb_o_retire_cnt, 32'd11);
    tick();

    // Reset mid-drain with stall toggling
    bus_if.wb_i_rf_ready = 1'b0;
    push_one(5'd1, 32'hA1, 32'h600);
    push_one(5'd2, 32'hA2, 32'h604);
    bus_if.wb_i_rf_ready = 1'b1;
    bus_if.wb_i_stall = 1'b1;
    tick();
    bus_if.wb_i_stall = 1'b0;
    tick();
    chk("stall_retire", bus_if.wb_o_retire_cnt, 32'd12);
    bus_if.wb_i_stall = 1'b1;
    wb_rst = 1'b1;
    tick();
    wb_rst = 1'b0;
    bus_if.wb_i_stall = 1'b0;
    #1;
    chk("rst_valid", bus_if.wb_o_valid, 1'b0);
    chk("rst_we", bus_if.wb_o_we_rd, 1'b0);
    chk("rst_rd", bus_if.wb_o_rd_addr, 5'd0);
    chk("rst_data", bus_if.wb_o_rd_data, 32'd0);
    chk("rst_npc", bus_if.wb_o_next_pc, 32'd0);
    chk("rst_retire", bus_if.wb_o_retire_cnt, 32'd0);
    chk("rst_ready", bus_if.wb_o_ready, 1'b1);
    push_one(5'd3, 32'hB3, 32'hFFFFFFFC);
    chk("npc_wrap", bus_if.wb_o_next_pc, 32'd0);
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
